// File: rtl/strana_tx_pkg.sv
`default_nettype none
// ============================================================================
// strana_tx_pkg : shared types, default pulse timings and receiver threshold
// Revision 1.0
// ============================================================================
package strana_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_WAIT = 2'd3
    } state_e;

    localparam int CNT_W         = 4;
    localparam int DEF_SHORT_LOW = 4;
    localparam int DEF_LONG_LOW  = 12;
    localparam int DEF_GAP       = 4;
    // A low pulse shorter than this many cycles decodes as a 1 at the receiver.
    localparam int RX_THRESHOLD  = 8;

    function automatic logic [CNT_W-1:0] pulse_len_m1(
        input logic bit_v,
        input int   short_low,
        input int   long_low
    );
        return bit_v ? CNT_W'(short_low - 1) : CNT_W'(long_low - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/strana_tx_timer.sv
`default_nettype none
// ============================================================================
// strana_tx_timer : 4-bit loadable down-counter that parks at zero
// Revision 1.0
// ============================================================================
module strana_tx_timer
    import strana_tx_pkg::*;
(
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/strana_seriale_tx.sv
`default_nettype none
// ============================================================================
// strana_seriale_tx : pulse-width serial LED-frame transmitter, 4-phase input
// Revision 1.0 -- optional done pulse output enabled by STRANA_TX_DONE_EN
// ============================================================================
module strana_seriale_tx
    import strana_tx_pkg::*;
#(
    parameter int SHORT_LOW = DEF_SHORT_LOW,
    parameter int LONG_LOW  = DEF_LONG_LOW,
    parameter int GAP       = DEF_GAP
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       dav_n_i,
    input  logic [4:0] addr_i,
    input  logic [2:0] val_i,
    output logic       rfd_o,
    output logic       txd_o
`ifdef STRANA_TX_DONE_EN
    ,
    output logic       done_o
`endif
);

    localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(GAP - 1);

    state_e           state_q, state_d;
    logic [7:0]       frame_q, frame_d;
    logic [2:0]       idx_q, idx_d;
    logic             txd_q, txd_d;
    logic             rfd_q, rfd_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic [2:0]       w_next_idx;
`ifdef STRANA_TX_DONE_EN
    logic             done_q, done_d;
`endif

    assign w_next_idx = idx_q + 3'd1;

    strana_tx_timer u_timer (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        idx_d    = idx_q;
        txd_d    = txd_q;
        rfd_d    = rfd_q;
        tmr_load = 1'b0;
        tmr_val  = GAP_M1;
`ifdef STRANA_TX_DONE_EN
        done_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!dav_n_i) begin
                    frame_d  = {addr_i, val_i};
                    idx_d    = 3'd0;
                    rfd_d    = 1'b0;
                    txd_d    = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = pulse_len_m1(val_i[0], SHORT_LOW, LONG_LOW);
                    state_d  = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tmr_zero) begin
                    txd_d    = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_M1;
                    state_d  = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tmr_zero) begin
                    if (idx_q != 3'd7) begin
                        idx_d    = w_next_idx;
                        txd_d    = 1'b0;
                        tmr_load = 1'b1;
                        tmr_val  = pulse_len_m1(frame_q[w_next_idx], SHORT_LOW, LONG_LOW);
                        state_d  = ST_LOW;
                    end else begin
                        state_d  = ST_WAIT;
`ifdef STRANA_TX_DONE_EN
                        done_d   = 1'b1;
`endif
                    end
                end
            end
            ST_WAIT: begin
                // Producer must release dav_ before the next frame can start.
                if (dav_n_i) begin
                    rfd_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
                rfd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            frame_q <= 8'd0;
            idx_q   <= 3'd0;
            txd_q   <= 1'b1;
            rfd_q   <= 1'b1;
`ifdef STRANA_TX_DONE_EN
            done_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            txd_q   <= txd_d;
            rfd_q   <= rfd_d;
`ifdef STRANA_TX_DONE_EN
            done_q  <= done_d;
`endif
        end
    end

    assign txd_o = txd_q;
    assign rfd_o = rfd_q;
`ifdef STRANA_TX_DONE_EN
    assign done_o = done_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_strana_seriale_tx.sv
`default_nettype none
// ============================================================================
// tb_strana_seriale_tx : directed + random frames against a waveform model
// Revision 1.0
// ============================================================================
module tb_strana_seriale_tx;

    localparam int SL = 4;
    localparam int LL = 12;
    localparam int GP = 4;
    localparam int THR = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       dav_n;
    logic [4:0] addr;
    logic [2:0] val;
    logic       rfd;
    logic       txd;
`ifdef STRANA_TX_DONE_EN
    logic       done;
`endif

    int total = 0;
    int bad   = 0;

    strana_seriale_tx #(
        .SHORT_LOW (SL),
        .LONG_LOW  (LL),
        .GAP       (GP)
    ) dut (
        .clock_i (clk),
        .reset_i (reset),
        .dav_n_i (dav_n),
        .addr_i  (addr),
        .val_i   (val),
        .rfd_o   (rfd),
        .txd_o   (txd)
`ifdef STRANA_TX_DONE_EN
        ,
        .done_o  (done)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge with the DUT idle; drives one frame and
    // checks every txd cycle against the ideal pulse train of the byte.
    task automatic send_frame(input logic [4:0] a, input logic [2:0] v,
                              input int hold, input bit noisy,
                              output logic [7:0] rx);
        logic [7:0] f;
        logic       exp_q[$];
        int         run;
        int         nbits;
        f = {a, v};
        for (int i = 0; i < 8; i++) begin
            repeat (f[i] ? SL : LL) exp_q.push_back(1'b0);
            repeat (GP) exp_q.push_back(1'b1);
        end
        chk("idle_rfd", rfd, 1);
        chk("idle_txd", txd, 1);
        dav_n = 1'b0;
        addr  = a;
        val   = v;
        rx    = 8'd0;
        run   = 0;
        nbits = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            chk("frame_txd", txd, exp_q[k]);
            chk("frame_rfd", rfd, 0);
`ifdef STRANA_TX_DONE_EN
            chk("frame_done", done, 0);
`endif
            if (txd == 1'b0) begin
                run++;
            end else if (run > 0) begin
                if (nbits < 8) rx[nbits] = (run < THR);
                nbits++;
                run = 0;
            end
            if (noisy) begin
                addr  = 5'($urandom);
                val   = 3'($urandom);
                dav_n = 1'($urandom);
            end
            if (k == exp_q.size() - 1) dav_n = 1'b0;
        end
        chk("rx_bitcount", nbits, 8);
        @(negedge clk);
        chk("wait_txd", txd, 1);
        chk("wait_rfd", rfd, 0);
`ifdef STRANA_TX_DONE_EN
        chk("wait_done", done, 1);
`endif
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_txd", txd, 1);
            chk("hold_rfd", rfd, 0);
`ifdef STRANA_TX_DONE_EN
            chk("hold_done", done, 0);
`endif
        end
        dav_n = 1'b1;
        @(negedge clk);
        chk("release_rfd", rfd, 1);
        chk("release_txd", txd, 1);
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] f;
        logic [2:0] led;
        int         offset;
        logic [4:0] ra;
        logic [2:0] rv;

        reset = 1'b1;
        dav_n = 1'b1;
        addr  = 5'd0;
        val   = 3'd0;
        led   = 3'd0;
        #2;
        chk("reset_txd", txd, 1);
        chk("reset_rfd", rfd, 1);
`ifdef STRANA_TX_DONE_EN
        chk("reset_done", done, 0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // First capture on the first rising edge after reset release.
        send_frame(5'b10101, 3'b011, 0, 1'b0, rx);
        chk("rx_10101_011", rx, 8'hAB);

        // All-zero frame: eight long pulses, 128 cycles to WAIT, long hold.
        send_frame(5'b00000, 3'b000, 4, 1'b0, rx);
        chk("rx_zero", rx, 8'h00);

        send_frame(5'b11111, 3'b111, 1, 1'b0, rx);
        chk("rx_ones", rx, 8'hFF);

        // Abort mid-LOW of bit 3, asynchronously.
        f = 8'b0110_0101;
        @(negedge clk);
        dav_n = 1'b0;
        addr  = f[7:3];
        val   = f[2:0];
        offset = 2;
        for (int i = 0; i < 3; i++) offset += (f[i] ? SL : LL) + GP;
        repeat (offset) @(negedge clk);
        chk("abort_pre_txd", txd, 0);
        #1 reset = 1'b1;
        #1;
        chk("abort_txd", txd, 1);
        chk("abort_rfd", rfd, 1);
        dav_n = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send_frame(5'b01100, 3'b101, 0, 1'b0, rx);
        chk("rx_after_abort", rx, 8'h65);

        // Loopback through a receiver whose own address is 10101.
        send_frame(5'b10101, 3'b110, 0, 1'b0, rx);
        if (rx[7:3] == 5'b10101) led = rx[2:0];
        chk("led_match", led, 3'b110);
        send_frame(5'b00001, 3'b111, 0, 1'b0, rx);
        if (rx[7:3] == 5'b10101) led = rx[2:0];
        chk("led_unchanged", led, 3'b110);

        // Random frames with input churn after capture.
        for (int n = 0; n < 8; n++) begin
            ra = 5'($urandom);
            rv = 3'($urandom);
            send_frame(ra, rv, int'($urandom_range(0, 2)), 1'b1, rx);
            chk("rx_random", rx, {ra, rv});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
